regfile_write_queue: RTL and testbench
======================================

// Module: regfile_write_queue
//
// PURPOSE
// Write-side front end for the 8x16 register file: buffers register writebacks from the pipeline
// and issues at most one write per cycle into the register file's single write port.
// Absorbs write-port stalls without stalling the producer until the queue is full.
// Provides two lookup ports so decode can read values still pending in the queue, newest first.
//
// PARAMETERS
// DEPTH  4   queue entries; power of two, >= 2
// AW     3   register address width (8 registers)
// DW     16  register data width
//
// PORTS
// clk        in   1    clock; all state updates on rising edge
// rst        in   1    reset, synchronous, active-high
// in_valid   in   1    producer has a write to enqueue
// in_ready   out  1    queue can accept; = (count < DEPTH)
// in_addr    in   AW   destination register
// in_data    in   DW   writeback value
// rf_stall   in   1    register file cannot take a write this cycle
// wr_en      out  1    write strobe to register file
// wr_addr    out  AW   register file write address
// wr_data    out  DW   register file write data
// lk_addr1   in   AW   lookup port 1 address
// lk_hit1    out  1    a pending entry targets lk_addr1
// lk_data1   out  DW   data of the youngest matching entry; 0 when no hit
// lk_addr2   in   AW   lookup port 2 address
// lk_hit2    out  1    as lk_hit1, for lk_addr2
// lk_data2   out  DW   as lk_data1, for lk_addr2
// count      out  log2(DEPTH)+1  number of valid entries
//
// BEHAVIOUR
// - Circular FIFO: head/tail pointers, log2(DEPTH) bits each, wrap modulo DEPTH; count in 0..DEPTH.
// - Reset (rst=1 at clk edge): head=tail=0, count=0; all entries invalid. Outputs after reset:
//   in_ready=1, wr_en=0, wr_addr=0, wr_data=0, lk_hit*=0, lk_data*=0, count=0. rst overrides
//   push/pop in the same cycle; entries pending at reset are discarded (not written).
// - push = in_valid & in_ready; stores {in_addr,in_data} at tail, tail++ at the edge.
// - in_ready depends only on registered count; full queue refuses even if a pop occurs that cycle.
// - wr_en = (count!=0) & ~rf_stall, combinational. wr_addr/wr_data = head entry when count!=0,
//   else 0. pop = wr_en; head++ at the edge.
// - push & pop same cycle: count unchanged. Empty + push: entry visible at head next cycle
//   (1-cycle min latency in_valid -> wr_en); no combinational in->wr bypass.
// - Writes leave in enqueue order; two entries to the same address both issue, oldest first.
// - Lookups: combinational over valid entries only (head..tail-1); head entry counts even in the
//   cycle it is popped. Multiple matches -> youngest (closest to tail) wins. Incoming in_* of
//   the current cycle is NOT searched.
// - rf_stall held indefinitely: queue fills to DEPTH, in_ready=0, contents and lookups stable.
//
// CONFIGURATION
// WQ_COALESCE_EN defined: a push whose in_addr equals the youngest valid entry's address, and
//   that entry is not being popped this cycle, overwrites that entry's data in place; tail and
//   count unchanged. Coalescing is allowed when full: in_ready = (count<DEPTH) | coalesce_hit.
// WQ_COALESCE_EN undefined: every push allocates a new entry; in_ready = (count<DEPTH).
//
// TESTING
// 1. Reset, idle: count=0, in_ready=1, wr_en=0, lk_hit1=lk_hit2=0, all data outputs 0.
// 2. Push (r3,0x1234) into empty, rf_stall=0 -> next cycle wr_en=1, wr_addr=3, wr_data=0x1234; count 1->0.
// 3. rf_stall=1, push r1=0x0001,r2=0x0002,r1=0x00AA,r5=0x0005 -> count=4, in_ready=0;
//    lk_addr1=1 -> hit, 0x00AA; lk_addr2=7 -> hit=0, data 0. Release stall -> writes r1,r2,r1,r5 in order.
// 4. Full queue, pop and push same cycle -> push refused (in_ready=0); next cycle count=3, in_ready=1.
// 5. rst asserted with 3 entries pending -> next cycle count=0, wr_en=0, no pending entry ever written.
// 6. WQ_COALESCE_EN: stall, push r4=0x0010 then r4=0x0020 -> count=1, lookup r4=0x0020; release -> single write.

Source files
------------

// File: rtl/regfile_write_queue.sv
// Write queue in front of the 8x16 register file write port, with
// newest-first lookup. Define WQ_COALESCE_EN to merge same-address pushes.
module regfile_write_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 3,
   parameter int DW    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [AW-1:0]            in_addr,
   input  logic [DW-1:0]            in_data,
   input  logic                     rf_stall,
   output logic                     wr_en,
   output logic [AW-1:0]            wr_addr,
   output logic [DW-1:0]            wr_data,
   input  logic [AW-1:0]            lk_addr1,
   output logic                     lk_hit1,
   output logic [DW-1:0]            lk_data1,
   input  logic [AW-1:0]            lk_addr2,
   output logic                     lk_hit2,
   output logic [DW-1:0]            lk_data2,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] r_addr [DEPTH];
   logic [DW-1:0] r_data [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;

   logic          w_nonempty;
   logic          w_pop;
   logic          w_push;
   logic          w_coal;
   logic          w_alloc;
   logic [PW-1:0] w_young;
   logic [PW-1:0] w_idx;

   assign w_nonempty = (r_count != '0);
   assign w_pop      = w_nonempty & ~rf_stall;
   assign w_young    = r_tail - PW'(1);

`ifdef WQ_COALESCE_EN
   // Youngest entry may absorb the push unless it leaves this cycle.
   assign w_coal   = w_nonempty
                   & (r_addr[w_young] == in_addr)
                   & ~(w_pop & (r_count == CW'(1)));
   assign in_ready = (r_count < CW'(DEPTH)) | w_coal;
`else
   assign w_coal   = 1'b0;
   assign in_ready = (r_count < CW'(DEPTH));
`endif

   assign w_push  = in_valid & in_ready;
   assign w_alloc = w_push & ~w_coal;

   assign wr_en   = w_pop;
   assign wr_addr = w_nonempty ? r_addr[r_head] : '0;
   assign wr_data = w_nonempty ? r_data[r_head] : '0;
   assign count   = r_count;

   // Scan oldest to youngest so the youngest match is the one left standing.
   always_comb begin
      lk_hit1  = 1'b0;
      lk_data1 = '0;
      lk_hit2  = 1'b0;
      lk_data2 = '0;
      w_idx    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = r_head + PW'(i);
         if (CW'(i) < r_count) begin
            if (r_addr[w_idx] == lk_addr1) begin
               lk_hit1  = 1'b1;
               lk_data1 = r_data[w_idx];
            end
            if (r_addr[w_idx] == lk_addr2) begin
               lk_hit2  = 1'b1;
               lk_data2 = r_data[w_idx];
            end
         end
      end
   end

   // Pointer and occupancy update; reset discards pending entries.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_pop)   r_head <= r_head + PW'(1);
         if (w_alloc) r_tail <= r_tail + PW'(1);
         r_count <= r_count + CW'(w_alloc) - CW'(w_pop);
      end
   end

   // Entry storage: allocate at tail or merge into the youngest entry.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_alloc) begin
            r_addr[r_tail] <= in_addr;
            r_data[r_tail] <= in_data;
         end
         if (w_push & w_coal)
            r_data[w_young] <= in_data;
      end
   end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Bench for regfile_write_queue: directed vector table, hand sequences
// for reset/coalescing, and random traffic against a queue model.
module tb_regfile_write_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_addr;
   logic [15:0] in_data;
   logic        rf_stall;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic [2:0]  lk_addr1;
   logic        lk_hit1;
   logic [15:0] lk_data1;
   logic [2:0]  lk_addr2;
   logic        lk_hit2;
   logic [15:0] lk_data2;
   logic [2:0]  count;

   regfile_write_queue #(.DEPTH(DEPTH), .AW(3), .DW(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data),
      .rf_stall(rf_stall),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .lk_addr1(lk_addr1), .lk_hit1(lk_hit1), .lk_data1(lk_data1),
      .lk_addr2(lk_addr2), .lk_hit2(lk_hit2), .lk_data2(lk_data2),
      .count(count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rdy;
      logic        we;
      logic [2:0]  wa;
      logic [15:0] wd;
      logic        h1;
      logic [15:0] d1;
      logic        h2;
      logic [15:0] d2;
      logic [2:0]  cnt;
   } out_t;

   typedef struct packed {
      logic        r;
      logic        v;
      logic [2:0]  a;
      logic [15:0] d;
      logic        s;
      logic [2:0]  l1;
      logic [2:0]  l2;
      out_t        e;
   } vec_t;

   typedef struct packed {
      logic [2:0]  a;
      logic [15:0] d;
   } ent_t;

   int   n_pass = 0;
   int   n_tot  = 0;
   ent_t mq[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot++;
      if (act !== exp)
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      else
         n_pass++;
   endtask

   task automatic chk_all(input string nm, input out_t e);
      chk({nm, ".in_ready"}, 32'(in_ready), 32'(e.rdy));
      chk({nm, ".wr_en"},    32'(wr_en),    32'(e.we));
      chk({nm, ".wr_addr"},  32'(wr_addr),  32'(e.wa));
      chk({nm, ".wr_data"},  32'(wr_data),  32'(e.wd));
      chk({nm, ".lk_hit1"},  32'(lk_hit1),  32'(e.h1));
      chk({nm, ".lk_data1"}, 32'(lk_data1), 32'(e.d1));
      chk({nm, ".lk_hit2"},  32'(lk_hit2),  32'(e.h2));
      chk({nm, ".lk_data2"}, 32'(lk_data2), 32'(e.d2));
      chk({nm, ".count"},    32'(count),    32'(e.cnt));
   endtask

   task automatic drive(input logic r, input logic v, input logic [2:0] a,
                        input logic [15:0] d, input logic s,
                        input logic [2:0] l1, input logic [2:0] l2);
      rst      = r;
      in_valid = v;
      in_addr  = a;
      in_data  = d;
      rf_stall = s;
      lk_addr1 = l1;
      lk_addr2 = l2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: the queue holds pending writes oldest-first.
   function automatic out_t model_out();
      out_t o;
      int   n;
      logic coal;
      n = mq.size();
      o = '0;
      o.cnt = 3'(n);
      o.we  = (n != 0) && !rf_stall;
      if (n != 0) begin
         o.wa = mq[0].a;
         o.wd = mq[0].d;
      end
      for (int i = n - 1; i >= 0; i--) begin
         if (!o.h1 && mq[i].a == lk_addr1) begin
            o.h1 = 1'b1;
            o.d1 = mq[i].d;
         end
         if (!o.h2 && mq[i].a == lk_addr2) begin
            o.h2 = 1'b1;
            o.d2 = mq[i].d;
         end
      end
      coal = 1'b0;
`ifdef WQ_COALESCE_EN
      coal = (n != 0) && (mq[n-1].a == in_addr) && !(o.we && n == 1);
`endif
      o.rdy = (n < DEPTH) || coal;
      return o;
   endfunction

   task automatic model_update(input out_t o);
      logic coal;
      if (rst) begin
         mq.delete();
         return;
      end
      coal = 1'b0;
`ifdef WQ_COALESCE_EN
      coal = (mq.size() != 0) && (mq[mq.size()-1].a == in_addr)
           && !(o.we && mq.size() == 1);
`endif
      if (o.we) void'(mq.pop_front());
      if (in_valid && o.rdy) begin
         if (coal) mq[mq.size()-1].d = in_data;
         else      mq.push_back('{a: in_addr, d: in_data});
      end
   endtask

   vec_t vt[15];

   initial begin
      out_t e;

      // rdy we wa wd h1 d1 h2 d2 cnt
      vt[0]  = '{0,0,3'd0,16'h0,0,3'd0,3'd5,
                 '{1,0,3'd0,16'h0,0,16'h0,0,16'h0,3'd0}};
      vt[1]  = '{0,1,3'd3,16'h1234,0,3'd3,3'd0,
                 '{1,0,3'd0,16'h0,0,16'h0,0,16'h0,3'd0}};
      vt[2]  = '{0,0,3'd0,16'h0,0,3'd3,3'd4,
                 '{1,1,3'd3,16'h1234,1,16'h1234,0,16'h0,3'd1}};
      vt[3]  = '{0,0,3'd0,16'h0,0,3'd3,3'd0,
                 '{1,0,3'd0,16'h0,0,16'h0,0,16'h0,3'd0}};
      vt[4]  = '{0,1,3'd1,16'h0001,1,3'd1,3'd0,
                 '{1,0,3'd0,16'h0,0,16'h0,0,16'h0,3'd0}};
      vt[5]  = '{0,1,3'd2,16'h0002,1,3'd1,3'd2,
                 '{1,0,3'd1,16'h0001,1,16'h0001,0,16'h0,3'd1}};
      vt[6]  = '{0,1,3'd1,16'h00AA,1,3'd1,3'd2,
                 '{1,0,3'd1,16'h0001,1,16'h0001,1,16'h0002,3'd2}};
      vt[7]  = '{0,1,3'd5,16'h0005,1,3'd1,3'd5,
                 '{1,0,3'd1,16'h0001,1,16'h00AA,0,16'h0,3'd3}};
      vt[8]  = '{0,0,3'd0,16'h0,1,3'd1,3'd7,
                 '{0,0,3'd1,16'h0001,1,16'h00AA,0,16'h0,3'd4}};
      vt[9]  = '{0,1,3'd6,16'h0066,1,3'd6,3'd5,
                 '{0,0,3'd1,16'h0001,0,16'h0,1,16'h0005,3'd4}};
      vt[10] = '{0,1,3'd6,16'h0066,0,3'd6,3'd2,
                 '{0,1,3'd1,16'h0001,0,16'h0,1,16'h0002,3'd4}};
      vt[11] = '{0,0,3'd0,16'h0,0,3'd1,3'd2,
                 '{1,1,3'd2,16'h0002,1,16'h00AA,1,16'h0002,3'd3}};
      vt[12] = '{0,0,3'd0,16'h0,0,3'd5,3'd2,
                 '{1,1,3'd1,16'h00AA,1,16'h0005,0,16'h0,3'd2}};
      vt[13] = '{0,0,3'd0,16'h0,0,3'd1,3'd6,
                 '{1,1,3'd5,16'h0005,0,16'h0,0,16'h0,3'd1}};
      vt[14] = '{0,0,3'd0,16'h0,0,3'd5,3'd6,
                 '{1,0,3'd0,16'h0,0,16'h0,0,16'h0,3'd0}};

      drive(1, 0, 0, 0, 0, 0, 0);
      tick();
      tick();

      for (int i = 0; i < 15; i++) begin
         drive(vt[i].r, vt[i].v, vt[i].a, vt[i].d, vt[i].s,
               vt[i].l1, vt[i].l2);
         #3;
         chk_all($sformatf("vec%0d", i), vt[i].e);
         tick();
      end

      // Reset while three writes are pending: none may ever issue.
      drive(0, 1, 3'd2, 16'h0202, 1, 0, 0);
      tick();
      drive(0, 1, 3'd3, 16'h0303, 1, 0, 0);
      tick();
      drive(0, 1, 3'd4, 16'h0404, 1, 0, 0);
      tick();
      drive(1, 1, 3'd6, 16'h0606, 0, 3'd3, 3'd4);
      #3;
      chk("rst.pre_count", 32'(count), 32'd3);
      tick();
      drive(0, 0, 0, 0, 0, 3'd3, 3'd6);
      for (int i = 0; i < 4; i++) begin
         #3;
         chk($sformatf("rst.post%0d.wr_en", i), 32'(wr_en), 32'd0);
         chk($sformatf("rst.post%0d.count", i), 32'(count), 32'd0);
         chk($sformatf("rst.post%0d.hit1", i), 32'(lk_hit1), 32'd0);
         chk($sformatf("rst.post%0d.hit2", i), 32'(lk_hit2), 32'd0);
         tick();
      end

`ifdef WQ_COALESCE_EN
      // Two writes to r4 while stalled merge into one entry.
      drive(0, 1, 3'd4, 16'h0010, 1, 3'd4, 3'd0);
      tick();
      drive(0, 1, 3'd4, 16'h0020, 1, 3'd4, 3'd0);
      #3;
      chk("coal.ready", 32'(in_ready), 32'd1);
      tick();
      drive(0, 0, 0, 0, 1, 3'd4, 3'd0);
      #3;
      chk("coal.count", 32'(count), 32'd1);
      chk("coal.lk_data", 32'(lk_data1), 32'h0020);
      tick();
      drive(0, 0, 0, 0, 0, 3'd4, 3'd0);
      #3;
      chk("coal.wr_en", 32'(wr_en), 32'd1);
      chk("coal.wr_data", 32'(wr_data), 32'h0020);
      tick();
      #3;
      chk("coal.single", 32'(wr_en), 32'd0);
      chk("coal.empty", 32'(count), 32'd0);
      tick();
`endif

      // Random traffic against the queue model.
      drive(1, 0, 0, 0, 0, 0, 0);
      tick();
      mq.delete();
      for (int c = 0; c < 600; c++) begin
         drive(($urandom_range(0, 59) == 0),
               ($urandom_range(0, 2) != 0),
               3'($urandom_range(0, 7)),
               16'($urandom),
               ($urandom_range(0, 9) < ((c / 100) % 2 == 0 ? 3 : 8)),
               3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)));
         #3;
         e = model_out();
         chk_all($sformatf("rnd%0d", c), e);
         model_update(e);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
